kcore_write_back: RTL and testbench
===================================

# kcore_write_back

Write-back stage of the k-core dataflow pipeline: the consumer of the `start_for_write_back` start-token FIFO. Each start token launches one write-back pass. The pass accepts a stream of (vertex id, core value) update records, merges runs of consecutive vertex ids into bursts, and writes them to the core-value array in memory through a burst write master. It pulses `done` once the final burst response of the pass returns.

## Interface
Parameters:
- `ADDR_W`, 32: memory byte-address width.
- `DATA_W`, 32: core value width. It equals the memory word width (4 bytes per vertex).
- `VID_W`, 32: vertex id width.
- `BURST_LEN`, 16: maximum beats per burst, range 1..256.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_empty_n`  in  1  start-token FIFO holds a token.
- `start_read`  out  1  consume one start token.
- `base_addr`  in  ADDR_W  core array base; 4 KiB aligned; sampled at token consume.
- `upd_valid`  in  1  update record valid.
- `upd_ready`  out  1  record accepted when high with `upd_valid`.
- `upd_vid`  in  VID_W  vertex id.
- `upd_core`  in  DATA_W  new core value.
- `upd_last`  in  1  final record of the pass.
- `aw_valid`  out  1, `aw_ready`  in  1, `aw_addr`  out  ADDR_W, `aw_len`  out  8 (beats−1): write-address channel.
- `w_valid`  out  1, `w_ready`  in  1, `w_data`  out  DATA_W, `w_last`  out  1: write-data channel.
- `b_valid`  in  1, `b_ready`  out  1, `b_resp`  in  2: write-response channel.
- `done`  out  1  one-cycle pulse at pass end.
- `wb_count`  out  32  records written in the current or last pass.
- `err`  out  1  sticky; set when any `b_resp` is not 0 during the pass.

## Operation
States are IDLE, FILL, AW, W, B and DONE.

- **IDLE:** when `start_empty_n`=1, assert `start_read` for exactly one cycle and go to FILL. In the same cycle: latch `base_addr`, clear `wb_count`, `err`, buffer count `cnt` and `last_seen`.
- **FILL:** the next record is acceptable when `cnt`==0, or when `upd_vid`==`first_vid`+`cnt` (mod 2^VID_W) and `cnt`<BURST_LEN.
  - `upd_ready` is high only in FILL and only when the record is acceptable.
  - On acceptance: store `upd_core` at buffer[`cnt`], increment `cnt` and `wb_count`, and record `first_vid` if `cnt` was 0.
  - Go to AW when any of these holds:
    - the accepted record had `upd_last`=1 (this also sets `last_seen`);
    - `cnt` reaches BURST_LEN;
    - (`first_vid`+`cnt`)[9:0]==0, i.e. the 4 KiB boundary;
    - `upd_valid`=1 with a non-consecutive vid and `cnt`>0. In this case the record is not accepted; it is held for the next burst.
- **AW:** `aw_valid`=1, `aw_addr`=base+`first_vid`·4 (truncated to ADDR_W), `aw_len`=`cnt`−1. On `aw_ready`, go to W.
- **W:** emit buffer[0..`cnt`−1] in order, one beat per `w_ready`. `w_last` is high on beat `cnt`−1. After the last beat, go to B. Data beats never precede the address handshake.
- **B:** `b_ready`=1. On `b_valid`: if `b_resp`≠0, set `err`. Then go to DONE if `last_seen`, otherwise back to FILL with `cnt`=0.
- **DONE:** `done`=1 for one cycle, then IDLE. `wb_count` and `err` hold until the next token.

Reset: all outputs are 0 and the state is IDLE. The same applies to a reset mid-pass; the pass is abandoned, and no partial burst or done pulse follows.

## Timing
- Token consume occurs 1 cycle after `start_empty_n` rises while in IDLE. At most one token is consumed per pass.
- Accept to AW: the record that closes a burst moves the FSM to AW, and `aw_valid` is asserted on the next cycle.
- After `aw_ready`, `w_valid` is asserted on the following cycle. There are no bubbles between beats while `w_ready` is held high.
- `done` is asserted 1 cycle after the final `b_valid` handshake.
- All outputs are registered or decoded from the state plus registered data. There is no combinational path from `*_ready`/`*_valid` inputs to outputs, except `upd_ready`, which depends on `upd_vid`.

## Structure
- Package `kcore_wb_pkg` holds:
  - the state enum;
  - `RESP_OKAY`=2'b00;
  - `BYTES_PER_VERTEX`=4;
  - `PAGE_VERTICES`=1024.
- Sub-module `kcore_wb_burst_buf`: BURST_LEN×DATA_W register file with a write port (index and data) and a combinational read port.

## Test plan
- Hold `start_empty_n`=0 for 10 cycles, then raise it → no activity while low; `start_read` is high exactly 1 cycle; `wb_count`=0.
- base 0x1000, vids 10..14 with last on 14 → one AW with addr 0x1028 and len 4; 5 beats with `w_last` on beat 5; `done` 1 cycle after B; `wb_count`=5.
- vids 0..19, BURST_LEN=16 → AW len 15 at base, then AW len 3 at base+0x40; `wb_count`=20.
- vids 3, 4, 9 (last) → bursts at base+12 len 1 and base+36 len 0; `upd_ready`=0 on vid 9 until the first B completes.
- vids 1022..1025 → two bursts: base+0xFF8 len 1 and base+0x1000 len 1.
- Backpressure: `aw_ready` low 5 cycles, `w_ready` alternating, `b_resp`=2 → data order intact and `err`=1 at `done`. A separate run asserts `reset_n` low mid-W → all outputs 0 immediately, and there is no `done`.

Source files
------------

// File: rtl/kcore_wb_pkg.sv
// kcore_wb_pkg: shared states and constants for the k-core write-back stage.
package kcore_wb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_AW, S_W, S_B, S_DONE} wb_state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int BYTES_PER_VERTEX = 4;
    localparam int PAGE_VERTICES = 1024;
    localparam int PAGE_BITS = $clog2(PAGE_VERTICES);
endpackage

// File: rtl/kcore_wb_burst_buf.sv
// kcore_wb_burst_buf: burst staging register file, one write port, combinational read.
module kcore_wb_burst_buf #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IW-1:0]     i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IW-1:0]     i_ridx,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_widx] <= i_wdata;

    assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/kcore_write_back.sv
// kcore_write_back: merges consecutive-vid core updates into page-bounded bursts
// and writes them out through a burst write master, one pass per start token.
module kcore_write_back
    import kcore_wb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int VID_W     = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_empty_n,
    output logic              start_read,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [VID_W-1:0]  upd_vid,
    input  logic [DATA_W-1:0] upd_core,
    input  logic              upd_last,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic [7:0]        aw_len,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp,
    output logic              done,
    output logic [31:0]       wb_count,
    output logic              err
);
    localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    wb_state_t         r_state;
    logic [ADDR_W-1:0] r_base;
    logic [VID_W-1:0]  r_first_vid;
    logic [8:0]        r_cnt;
    logic [8:0]        r_beat;
    logic              r_last_seen;
    logic              r_start_read;
    logic              r_err;
    logic [31:0]       r_wb_count;
    logic              w_acc;
    logic              w_fire;
    logic              w_close;
    logic [8:0]        w_cnt_inc;
    logic [DATA_W-1:0] w_rdata;

    assign w_acc     = (r_cnt == 9'd0) ||
                       (upd_vid == r_first_vid + VID_W'(r_cnt) && r_cnt < 9'(BURST_LEN));
    assign upd_ready = (r_state == S_FILL) && w_acc;
    assign w_fire    = upd_valid && upd_ready;
    assign w_cnt_inc = r_cnt + 9'd1;
    // the next vid would start a new 4 KiB page when this one ends the current page
    assign w_close   = upd_last || w_cnt_inc == 9'(BURST_LEN) ||
                       upd_vid[PAGE_BITS-1:0] == {PAGE_BITS{1'b1}};

    assign start_read = r_start_read;
    assign aw_valid   = r_state == S_AW;
    assign aw_addr    = aw_valid ? r_base + ADDR_W'(r_first_vid) * ADDR_W'(BYTES_PER_VERTEX) : '0;
    assign aw_len     = aw_valid ? 8'(r_cnt - 9'd1) : '0;
    assign w_valid    = r_state == S_W;
    assign w_last     = w_valid && r_beat == r_cnt - 9'd1;
    assign w_data     = w_valid ? w_rdata : '0;
    assign b_ready    = r_state == S_B;
    assign done       = r_state == S_DONE;
    assign wb_count   = r_wb_count;
    assign err        = r_err;

    kcore_wb_burst_buf #(.DEPTH(BURST_LEN), .DATA_W(DATA_W), .IW(IW)) u_buf (
        .clk     (clk),
        .i_we    (w_fire),
        .i_widx  (r_cnt[IW-1:0]),
        .i_wdata (upd_core),
        .i_ridx  (r_beat[IW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_first_vid  <= '0;
            r_cnt        <= '0;
            r_beat       <= '0;
            r_last_seen  <= 1'b0;
            r_start_read <= 1'b0;
            r_err        <= 1'b0;
            r_wb_count   <= '0;
        end else begin
            r_start_read <= 1'b0;
            case (r_state)
                S_IDLE: if (start_empty_n) begin
                    r_start_read <= 1'b1;
                    r_base       <= base_addr;
                    r_wb_count   <= '0;
                    r_err        <= 1'b0;
                    r_cnt        <= '0;
                    r_last_seen  <= 1'b0;
                    r_state      <= S_FILL;
                end
                S_FILL: if (w_fire) begin
                    r_cnt      <= w_cnt_inc;
                    r_wb_count <= r_wb_count + 32'd1;
                    if (r_cnt == 9'd0) r_first_vid <= upd_vid;
                    if (upd_last) r_last_seen <= 1'b1;
                    if (w_close) r_state <= S_AW;
                end else if (upd_valid && r_cnt != 9'd0) begin
                    r_state <= S_AW;
                end
                S_AW: if (aw_ready) begin
                    r_beat  <= '0;
                    r_state <= S_W;
                end
                S_W: if (w_ready) begin
                    if (w_last) r_state <= S_B;
                    else r_beat <= r_beat + 9'd1;
                end
                S_B: if (b_valid) begin
                    if (b_resp != RESP_OKAY) r_err <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= r_last_seen ? S_DONE : S_FILL;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kcore_write_back.sv
// tb_kcore_write_back: directed passes against a small write-slave model.
module tb_kcore_write_back;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_empty_n, start_read;
    logic [31:0] base_addr;
    logic        upd_valid, upd_ready, upd_last;
    logic [31:0] upd_vid, upd_core;
    logic        aw_valid, w_valid, w_last, b_ready, done, err;
    logic        aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
    logic [1:0]  b_resp = 2'b00;
    logic [31:0] aw_addr, w_data, wb_count;
    logic [7:0]  aw_len;

    int tests = 0, fails = 0;
    logic [31:0] aw_q[$];
    int          len_q[$];
    logic [31:0] wd_q[$];
    logic        wl_q[$];
    int b_cnt = 0, done_cnt = 0, sr_cnt = 0, cyc = 0, b_cyc = 0, done_cyc = 0;
    int aw_stall = 0, aw_wait = 0, a0 = 0, w0 = 0, exp_done = 0;
    bit w_alt = 0, w_ph = 0, b_pend = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [31:0] exp_a[$];
    int exp_l[$];
    int exp_v[$];

    always #5 clk = ~clk;

    kcore_write_back dut (
        .clk(clk), .reset_n(reset_n), .start_empty_n(start_empty_n), .start_read(start_read),
        .base_addr(base_addr), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_vid(upd_vid),
        .upd_core(upd_core), .upd_last(upd_last), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .aw_addr(aw_addr), .aw_len(aw_len), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .w_last(w_last), .b_valid(b_valid), .b_ready(b_ready),
        .b_resp(b_resp), .done(done), .wb_count(wb_count), .err(err)
    );

    // slave drives on negedge, observes handshakes just before the next posedge
    always begin
        @(negedge clk);
        aw_ready = aw_valid && aw_wait >= aw_stall;
        w_ph = !w_ph;
        w_ready = !w_alt || w_ph;
        b_valid = b_pend;
        b_resp = b_pend ? bresp_cfg : 2'b00;
        #4;
        cyc++;
        if (!reset_n) begin
            b_pend = 0;
            aw_wait = 0;
        end else begin
            if (aw_valid && !aw_ready) aw_wait++;
            if (aw_valid && aw_ready) begin
                aw_q.push_back(aw_addr);
                len_q.push_back(int'(aw_len));
                aw_wait = 0;
            end
            if (w_valid && w_ready) begin
                wd_q.push_back(w_data);
                wl_q.push_back(w_last);
                if (w_last) b_pend = 1;
            end
            if (b_valid && b_ready) begin
                b_cnt++;
                b_cyc = cyc;
                b_pend = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (start_read) sr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({aw_valid, w_valid, w_last, b_ready, done, start_read, err, upd_ready}), 0);
        chk({tag, "_addr"}, aw_addr, 0);
        chk({tag, "_len"}, 32'(aw_len), 0);
        chk({tag, "_wdata"}, w_data, 0);
        chk({tag, "_count"}, wb_count, 0);
    endtask

    task automatic start_pass(input logic [31:0] base);
        int n = 0;
        a0 = aw_q.size();
        w0 = wd_q.size();
        base_addr = base;
        start_empty_n = 1;
        #1;
        while (!start_read && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("start_latency", n, 1);
        chk("count_cleared", wb_count, 0);
        chk("err_cleared", 32'(err), 0);
        start_empty_n = 0;
        @(negedge clk);
    endtask

    task automatic send(input int vid, input logic last, output logic rdy0, output int bc);
        int n = 0;
        upd_vid = vid;
        upd_core = vid * 3 + 256;
        upd_last = last;
        upd_valid = 1;
        #1;
        rdy0 = upd_ready;
        while (!upd_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        bc = b_cnt;
        chk("upd_accept", 32'(upd_ready), 1);
        @(negedge clk);
        upd_valid = 0;
        upd_last = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        exp_done++;
        while (done_cnt < exp_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt, exp_done);
        chk("done_after_b", done_cyc, b_cyc + 1);
        repeat (3) @(negedge clk);
        chk("done_single", done_cnt, exp_done);
    endtask

    task automatic chk_pass();
        int k = 0;
        int pos = 0;
        chk("aw_count", aw_q.size() - a0, exp_a.size());
        chk("beat_count", wd_q.size() - w0, exp_v.size());
        if (aw_q.size() - a0 == exp_a.size())
            for (int i = 0; i < exp_a.size(); i++) begin
                chk("aw_addr", aw_q[a0 + i], exp_a[i]);
                chk("aw_len", len_q[a0 + i], exp_l[i]);
            end
        if (wd_q.size() - w0 == exp_v.size())
            for (int i = 0; i < exp_v.size(); i++) begin
                chk("w_data", wd_q[w0 + i], exp_v[i] * 3 + 256);
                pos++;
                chk("w_last", 32'(wl_q[w0 + i]), 32'(pos == exp_l[k] + 1));
                if (pos == exp_l[k] + 1) begin
                    k++;
                    pos = 0;
                end
            end
    endtask

    initial begin #300000; $display("FAIL watchdog expired"); $fatal(1); end

    initial begin
        logic rdy0;
        int bc, n;
        start_empty_n = 0; base_addr = 0; upd_valid = 0; upd_vid = 0; upd_core = 0; upd_last = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1;
        repeat (10) @(negedge clk);
        chk("idle_no_read", sr_cnt, 0);
        chk("idle_no_aw", aw_q.size(), 0);

        start_pass(32'h1000);
        for (int v = 10; v <= 14; v++) send(v, v == 14, rdy0, bc);
        wait_done();
        exp_a = '{32'h1028}; exp_l = '{4}; exp_v = '{10, 11, 12, 13, 14};
        chk_pass();
        chk("count_5", wb_count, 5);
        chk("err_ok", 32'(err), 0);
        chk("one_token", sr_cnt, 1);

        start_pass(32'h2000);
        for (int v = 0; v <= 19; v++) send(v, v == 19, rdy0, bc);
        wait_done();
        exp_a = '{32'h2000, 32'h2040}; exp_l = '{15, 3}; exp_v = {};
        for (int v = 0; v <= 19; v++) exp_v.push_back(v);
        chk_pass();
        chk("count_20", wb_count, 20);

        start_pass(32'h3000);
        send(3, 0, rdy0, bc);
        send(4, 0, rdy0, bc);
        n = b_cnt;
        send(9, 1, rdy0, bc);
        chk("vid9_held", 32'(rdy0), 0);
        chk("vid9_after_b", bc, n + 1);
        wait_done();
        exp_a = '{32'h300C, 32'h3024}; exp_l = '{1, 0}; exp_v = '{3, 4, 9};
        chk_pass();
        chk("count_3", wb_count, 3);

        start_pass(32'h4000);
        for (int v = 1022; v <= 1025; v++) send(v, v == 1025, rdy0, bc);
        wait_done();
        exp_a = '{32'h4FF8, 32'h5000}; exp_l = '{1, 1}; exp_v = '{1022, 1023, 1024, 1025};
        chk_pass();

        aw_stall = 5; w_alt = 1; bresp_cfg = 2'b10;
        start_pass(32'h5000);
        for (int v = 100; v <= 103; v++) send(v, v == 103, rdy0, bc);
        wait_done();
        exp_a = '{32'h5190}; exp_l = '{3}; exp_v = '{100, 101, 102, 103};
        chk_pass();
        chk("err_set", 32'(err), 1);
        chk("count_4", wb_count, 4);
        aw_stall = 0; bresp_cfg = 2'b00;

        start_pass(32'h6000);
        for (int v = 200; v <= 203; v++) send(v, v == 203, rdy0, bc);
        n = 0;
        #1;
        while (!w_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("w_reached", 32'(w_valid), 1);
        reset_n = 0;
        #1;
        chk_zero("midw_reset");
        repeat (2) @(negedge clk);
        reset_n = 1;
        w_alt = 0;
        n = aw_q.size();
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", done_cnt, exp_done);
        chk("no_aw_after_reset", aw_q.size(), n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
